// File: rtl/weight_sram_ctrl_if.sv
// Purpose: handshake/bus bundle between the host loader, the coprocessor and
// the weight buffer.
//  master: host + coprocessor side (drives load stream and read requests)
//  slave : weight_sram_ctrl (returns load status and read data)
interface weight_sram_ctrl_if #(
    parameter int unsigned KERN_AW = 4,
    parameter int unsigned PIX_AW  = 6,
    parameter int unsigned DATA_W  = 8
);
    // Host load stream
    logic                loadStart;
    logic                loadValid;
    logic [DATA_W-1:0]   loadData;
    logic                loadReady;
    logic                loadDone;
    logic                weightsReady;
    // Coprocessor requests
    logic                enableWSRAM;
    logic                readWSRAM;
    logic                writeWSRAM;
    logic                readWifmaps;
    logic                readWpixels;
    logic [KERN_AW-1:0]  WkernAddr;
    logic [PIX_AW-1:0]   WpixAddr;
    // Read return
    logic [DATA_W-1:0]   weightOut;
    logic                weightValid;
    logic                burstLast;
    logic                busy;
    logic                accessError;

    modport master (
        output loadStart, loadValid, loadData,
        output enableWSRAM, readWSRAM, writeWSRAM, readWifmaps, readWpixels,
        output WkernAddr, WpixAddr,
        input  loadReady, loadDone, weightsReady,
        input  weightOut, weightValid, burstLast, busy, accessError
    );

    modport slave (
        input  loadStart, loadValid, loadData,
        input  enableWSRAM, readWSRAM, writeWSRAM, readWifmaps, readWpixels,
        input  WkernAddr, WpixAddr,
        output loadReady, loadDone, weightsReady,
        output weightOut, weightValid, burstLast, busy, accessError
    );
endinterface

// File: rtl/weight_sram_ctrl.sv
// Purpose: kernel-major weight buffer in front of the coprocessor. Loads a full
// weight set from the host stream, then serves single-word reads and
// whole-kernel bursts.
// Ports:
//  clock - system clock, rising edge
//  reset - asynchronous, active-low
//  bus   - weight_sram_ctrl_if.slave (load stream, read requests, read data)
module weight_sram_ctrl #(
    parameter int unsigned KERN_AW = 4,
    parameter int unsigned PIX_AW  = 6,
    parameter int unsigned DATA_W  = 8
) (
    input logic               clock,
    input logic               reset,
    weight_sram_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W = KERN_AW + PIX_AW;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LOAD_LAST = '1;
    localparam logic [PIX_AW-1:0] PIX_LAST  = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY, ST_BURST} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [ADDR_W-1:0]   r_load_addr;
    logic [KERN_AW-1:0]  r_kern;
    logic [PIX_AW-1:0]   r_pix;
    logic [DATA_W-1:0]   r_weight_out;
    logic                r_weight_valid;
    logic                r_burst_last;
    logic                r_busy;
    logic                r_access_error;
    logic                r_load_done;
    logic                r_load_ready;
    logic                r_weights_ready;

    logic [ADDR_W-1:0]   w_load_addr_nxt;
    logic [KERN_AW-1:0]  w_kern_nxt;
    logic [PIX_AW-1:0]   w_pix_nxt;
    logic                w_we;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_valid_nxt;
    logic                w_last_nxt;
    logic                w_err_nxt;
    logic                w_done_nxt;
    logic                w_req;
    logic                w_rd;

    assign w_req = bus.enableWSRAM & (bus.readWSRAM | bus.writeWSRAM);
    assign w_rd  = bus.enableWSRAM & bus.readWSRAM;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state, memory port and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_load_addr_nxt = r_load_addr;
        w_kern_nxt      = r_kern;
        w_pix_nxt       = r_pix;
        w_we            = 1'b0;
        w_rd_en         = 1'b0;
        w_rd_addr       = '0;
        w_valid_nxt     = 1'b0;
        w_last_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_err_nxt = w_req;
                if (bus.loadStart) begin
                    w_state_nxt     = ST_LOAD;
                    w_load_addr_nxt = '0;
                end
            end
            ST_LOAD: begin
                w_err_nxt = w_req;
                if (bus.loadValid) begin
                    w_we            = 1'b1;
                    w_load_addr_nxt = r_load_addr + 1'b1;
                    if (r_load_addr == LOAD_LAST) begin
                        w_state_nxt = ST_READY;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (bus.enableWSRAM && bus.writeWSRAM) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.loadStart) begin
                    w_state_nxt     = ST_LOAD;
                    w_load_addr_nxt = '0;
                end else if (w_rd && bus.readWifmaps) begin
                    // Word 0 is fetched on the request cycle; the counter
                    // then points at word 1.
                    w_state_nxt = ST_BURST;
                    w_kern_nxt  = bus.WkernAddr;
                    w_pix_nxt   = PIX_AW'(1);
                    w_rd_en     = 1'b1;
                    w_rd_addr   = {bus.WkernAddr, PIX_AW'(0)};
                    w_valid_nxt = 1'b1;
                end else if (w_rd && bus.readWpixels) begin
                    w_rd_en     = 1'b1;
                    w_rd_addr   = {bus.WkernAddr, bus.WpixAddr};
                    w_valid_nxt = 1'b1;
                end else if (w_rd) begin
                    w_err_nxt = 1'b1;
                end
            end
            ST_BURST: begin
                // Stay one extra cycle while the last word is on the output so
                // no request overlaps the burstLast cycle.
                if (r_burst_last) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_rd_en     = 1'b1;
                    w_rd_addr   = {r_kern, r_pix};
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (r_pix == PIX_LAST);
                    w_pix_nxt   = r_pix + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // SRAM write port; contents survive reset
    always_ff @(posedge clock) begin
        if (w_we) r_mem[r_load_addr] <= bus.loadData;
    end

    // Counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_load_addr     <= '0;
            r_kern          <= '0;
            r_pix           <= '0;
            r_weight_out    <= '0;
            r_weight_valid  <= 1'b0;
            r_burst_last    <= 1'b0;
            r_busy          <= 1'b0;
            r_access_error  <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_ready    <= 1'b0;
            r_weights_ready <= 1'b0;
        end else begin
            r_load_addr     <= w_load_addr_nxt;
            r_kern          <= w_kern_nxt;
            r_pix           <= w_pix_nxt;
            if (w_rd_en) r_weight_out <= r_mem[w_rd_addr];
            r_weight_valid  <= w_valid_nxt;
            r_burst_last    <= w_last_nxt;
            r_busy          <= (w_state_nxt == ST_BURST);
            r_access_error  <= w_err_nxt;
            r_load_done     <= w_done_nxt;
            r_load_ready    <= (w_state_nxt == ST_LOAD);
            r_weights_ready <= (w_state_nxt == ST_READY) || (w_state_nxt == ST_BURST);
        end
    end

    assign bus.weightOut    = r_weight_out;
    assign bus.weightValid  = r_weight_valid;
    assign bus.burstLast    = r_burst_last;
    assign bus.busy         = r_busy;
    assign bus.accessError  = r_access_error;
    assign bus.loadDone     = r_load_done;
    assign bus.loadReady    = r_load_ready;
    assign bus.weightsReady = r_weights_ready;
endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Bench for weight_sram_ctrl: directed load/read/burst/error/reset sequences,
// an expected-read queue built from a plain array image of the loaded weights,
// and a per-cycle compare process on the falling edge.
module tb_weight_sram_ctrl;
    localparam int unsigned KERN_AW = 4;
    localparam int unsigned PIX_AW  = 6;
    localparam int unsigned DATA_W  = 8;
    localparam int          DEPTH   = 1024;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    weight_sram_ctrl_if #(.KERN_AW(KERN_AW), .PIX_AW(PIX_AW), .DATA_W(DATA_W)) bus ();

    weight_sram_ctrl #(.KERN_AW(KERN_AW), .PIX_AW(PIX_AW), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       last;
    } exp_t;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       chk_en = 1'b0;
    exp_t       exp_q[$];
    int         err_q[$];
    int         done_due = -1;
    int         busy_lo = 0;
    int         busy_hi = -1;
    logic [7:0] model_mem [DEPTH];
    exp_t       ce;
    logic [9:0] cv;
    logic       ce_err;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int i);
        if (mode == 0) return 8'(i);
        return 8'(i * 37 + (i / 256) * 5 + 11);
    endfunction

    // Per-cycle comparison of every read/status pulse against the expectations
    always @(negedge clock) begin
        if (chk_en) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                ce = exp_q.pop_front();
                cv = {1'b1, ce.last, ce.data};
            end else begin
                cv = 10'b0;
            end
            chk("read_port", 32'({bus.weightValid, bus.burstLast,
                                  bus.weightValid ? bus.weightOut : 8'h00}), 32'(cv));
            ce_err = (err_q.size() != 0 && err_q[0] == cyc);
            if (ce_err) void'(err_q.pop_front());
            chk("access_error", 32'(bus.accessError), 32'(ce_err));
            chk("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            chk("load_done", 32'(bus.loadDone), 32'(cyc == done_due));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.loadStart   = 1'b0;
        bus.loadValid   = 1'b0;
        bus.enableWSRAM = 1'b0;
        bus.readWSRAM   = 1'b0;
        bus.writeWSRAM  = 1'b0;
        bus.readWifmaps = 1'b0;
        bus.readWpixels = 1'b0;
    endtask

    task automatic req_single(input logic [3:0] k, input logic [5:0] p);
        bus.enableWSRAM = 1'b1;
        bus.readWSRAM   = 1'b1;
        bus.writeWSRAM  = 1'b0;
        bus.readWifmaps = 1'b0;
        bus.readWpixels = 1'b1;
        bus.WkernAddr   = k;
        bus.WpixAddr    = p;
        exp_q.push_back('{cyc + 1, model_mem[{k, p}], 1'b0});
        tick();
    endtask

    task automatic req_burst(input logic [3:0] k, input logic both);
        bus.enableWSRAM = 1'b1;
        bus.readWSRAM   = 1'b1;
        bus.writeWSRAM  = 1'b0;
        bus.readWifmaps = 1'b1;
        bus.readWpixels = both;
        bus.WkernAddr   = k;
        bus.WpixAddr    = 6'd17;
        for (int p = 0; p < 64; p++)
            exp_q.push_back('{cyc + 1 + p, model_mem[{k, 6'(p)}], (p == 63)});
        busy_lo = cyc + 1;
        busy_hi = cyc + 64;
        tick();
    endtask

    task automatic req_err(input logic wr, input logic mode);
        bus.enableWSRAM = 1'b1;
        bus.readWSRAM   = ~wr;
        bus.writeWSRAM  = wr;
        bus.readWifmaps = 1'b0;
        bus.readWpixels = mode;
        err_q.push_back(cyc + 1);
        tick();
        idle();
    endtask

    task automatic load_set(input int mode, input logic gaps);
        logic [7:0] d;
        bus.loadStart = 1'b1;
        tick();
        bus.loadStart = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps) begin
                for (int g = 0; g < 2; g++) begin
                    bus.loadValid = 1'b0;
                    if (i == 100 && g == 0) bus.loadStart = 1'b1;
                    if (i == 200 && g == 0) begin
                        bus.enableWSRAM = 1'b1;
                        bus.readWSRAM   = 1'b1;
                        bus.readWpixels = 1'b1;
                        err_q.push_back(cyc + 1);
                    end
                    tick();
                    idle();
                end
            end
            d = pat(mode, i);
            model_mem[i]  = d;
            bus.loadValid = 1'b1;
            bus.loadData  = d;
            if (i == DEPTH - 1) done_due = cyc + 1;
            tick();
            if (i == 500) chk("load_ready_mid", 32'(bus.loadReady), 32'd1);
        end
        bus.loadValid = 1'b0;
    endtask

    initial begin
        idle();
        bus.loadData  = '0;
        bus.WkernAddr = '0;
        bus.WpixAddr  = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", 32'({bus.weightOut, bus.weightValid, bus.burstLast, bus.busy,
                                  bus.accessError, bus.loadDone, bus.loadReady,
                                  bus.weightsReady}), 32'd0);
        reset = 1'b1;
        tick();
        chk_en = 1'b1;

        // Requests before any load are rejected
        req_err(1'b0, 1'b1);
        req_err(1'b1, 1'b0);
        repeat (2) tick();
        chk("wready_before_load", 32'(bus.weightsReady), 32'd0);

        // Full load, data = address
        load_set(0, 1'b0);
        @(negedge clock);
        chk("load_ready_after", 32'(bus.loadReady), 32'd0);
        chk("wready_after_load", 32'(bus.weightsReady), 32'd1);
        tick();

        // Single and back-to-back reads
        req_single(4'd3, 6'd5);
        @(negedge clock);
        chk("rd_3_5", 32'(bus.weightOut), 32'h0C5);
        idle();
        tick();
        req_single(4'd3, 6'd0);
        @(negedge clock);
        chk("b2b_0", 32'(bus.weightOut), 32'h0C0);
        req_single(4'd3, 6'd1);
        @(negedge clock);
        chk("b2b_1", 32'(bus.weightOut), 32'h0C1);
        req_single(4'd3, 6'd2);
        @(negedge clock);
        chk("b2b_2", 32'(bus.weightOut), 32'h0C2);
        idle();
        tick();
        req_err(1'b0, 1'b0);
        tick();

        // Burst of kernel 2 with an ignored request mid-burst
        req_burst(4'd2, 1'b0);
        @(negedge clock);
        chk("burst_first", 32'(bus.weightOut), 32'h080);
        idle();
        repeat (8) tick();
        bus.enableWSRAM = 1'b1;
        bus.writeWSRAM  = 1'b1;
        bus.readWSRAM   = 1'b1;
        bus.readWpixels = 1'b1;
        bus.loadStart   = 1'b1;
        tick();
        idle();
        repeat (54) tick();
        @(negedge clock);
        chk("burst_last", 32'({bus.burstLast, bus.weightOut}), 32'h1BF);
        tick();
        chk("after_burst_hold", 32'({bus.weightValid, bus.busy, bus.weightOut}), 32'h0BF);
        chk("wready_after_burst", 32'(bus.weightsReady), 32'd1);
        req_single(4'd0, 6'd7);
        @(negedge clock);
        chk("rd_after_burst", 32'(bus.weightOut), 32'h007);
        idle();
        tick();

        // Invalidate, then reads fail
        bus.enableWSRAM = 1'b1;
        bus.writeWSRAM  = 1'b1;
        tick();
        chk("wready_invalidated", 32'(bus.weightsReady), 32'd0);
        idle();
        req_err(1'b0, 1'b1);
        repeat (2) tick();

        // Gappy reload with mid-load loadStart and read request
        load_set(1, 1'b1);
        @(negedge clock);
        chk("wready_reload", 32'(bus.weightsReady), 32'd1);
        tick();
        req_single(4'd4, 6'd44);
        @(negedge clock);
        chk("rd_4_44", 32'(bus.weightOut), 32'h06C);
        idle();
        tick();
        for (int k = 0; k < 16; k++) begin
            req_burst(4'(k), (k == 15));
            if (k == 0) begin
                @(negedge clock);
                chk("burst0_first", 32'(bus.weightOut), 32'h00B);
            end
            idle();
            repeat (64) tick();
        end

        // Reset during burst word 10
        req_burst(4'd5, 1'b0);
        idle();
        repeat (10) tick();
        @(negedge clock);
        #1;
        chk_en = 1'b0;
        exp_q.delete();
        err_q.delete();
        busy_hi = -1;
        reset = 1'b0;
        #1;
        chk("reset_mid_burst", 32'({bus.weightOut, bus.weightValid, bus.burstLast, bus.busy,
                                    bus.accessError, bus.loadDone, bus.loadReady,
                                    bus.weightsReady}), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        chk("wready_after_reset", 32'({bus.weightsReady, bus.busy, bus.loadReady}), 32'd0);
        req_err(1'b0, 1'b1);
        repeat (70) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
